// File: rtl/comp_4bit.sv
// Registered magnitude comparator, unsigned/signed, with 7485-style cascade inputs.
// 1-cycle latency; no backpressure, every in_valid is accepted and answered next cycle.
module comp_4bit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             signed_mode,
  input  logic             casc_gt,
  input  logic             casc_eq,
  input  logic             casc_lt,
  output logic             gt,
  output logic             eq,
  output logic             lt,
  output logic             out_valid
);

  logic [WIDTH-1:0] x_key;
  logic [WIDTH-1:0] y_key;
  logic             gt_nxt;
  logic             eq_nxt;
  logic             lt_nxt;

  // Flipping the sign bit maps two's-complement order onto unsigned order.
  assign x_key = {x[WIDTH-1] ^ signed_mode, x[WIDTH-2:0]};
  assign y_key = {y[WIDTH-1] ^ signed_mode, y[WIDTH-2:0]};

  always_comb begin
    gt_nxt = 1'b0;
    eq_nxt = 1'b0;
    lt_nxt = 1'b0;
    if (x_key > y_key) begin
      gt_nxt = 1'b1;
    end else if (x_key < y_key) begin
      lt_nxt = 1'b1;
    end else begin
      // Equal operands defer to the lower stage; casc_gt wins, then casc_lt, else equal.
      casez ({casc_gt, casc_lt, casc_eq})
        3'b1??:  gt_nxt = 1'b1;
        3'b01?:  lt_nxt = 1'b1;
        default: eq_nxt = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gt        <= 1'b0;
      eq        <= 1'b0;
      lt        <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        gt <= gt_nxt;
        eq <= eq_nxt;
        lt <= lt_nxt;
      end
    end
  end

endmodule

// File: tb/tb_comp_4bit.sv
// Self-checking bench for comp_4bit: directed vectors, streaming, async reset and exhaustive sweep.
module tb_comp_4bit;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] x;
  logic [3:0] y;
  logic       signed_mode;
  logic       casc_gt;
  logic       casc_eq;
  logic       casc_lt;
  logic       gt;
  logic       eq;
  logic       lt;
  logic       out_valid;

  int errors = 0;
  int checks = 0;
  logic [2:0] exp_q[$];

  comp_4bit #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .x(x), .y(y),
    .signed_mode(signed_mode), .casc_gt(casc_gt), .casc_eq(casc_eq), .casc_lt(casc_lt),
    .gt(gt), .eq(eq), .lt(lt), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  // Reference: integer-valued compare, result packed as {gt,eq,lt}.
  function automatic logic [2:0] model(input logic [3:0] a, input logic [3:0] b,
                                       input logic sm, input logic cg, input logic cl);
    int av;
    int bv;
    av = (sm && a >= 8) ? int'(a) - 16 : int'(a);
    bv = (sm && b >= 8) ? int'(b) - 16 : int'(b);
    if (av > bv) return 3'b100;
    if (av < bv) return 3'b001;
    if (cg) return 3'b100;
    if (cl) return 3'b001;
    return 3'b010;
  endfunction

  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic sm,
                      input logic cg, input logic ce, input logic cl, input logic [2:0] e);
    x = a; y = b; signed_mode = sm;
    casc_gt = cg; casc_eq = ce; casc_lt = cl;
    in_valid = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; x = '0; y = '0; signed_mode = 1'b0;
    casc_gt = 1'b0; casc_eq = 1'b1; casc_lt = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({out_valid, gt, eq, lt} !== 4'b0000) begin
      errors++;
      $display("FAIL reset: got {ov,gt,eq,lt}=%b want 0000", {out_valid, gt, eq, lt});
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_valid, gt, eq, lt} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_idle: got {ov,gt,eq,lt}=%b want 0000", {out_valid, gt, eq, lt});
    end
  endtask

  task automatic test_directed;
    // a, b, signed_mode, casc_gt, casc_eq, casc_lt, expected {gt,eq,lt}
    logic [3:0] ta[14] = '{4'h3, 4'h7, 4'h7, 4'h7, 4'h7, 4'h7, 4'h7, 4'h3, 4'h3, 4'h7, 4'h7, 4'h0, 4'h8, 4'h2};
    logic [3:0] tb[14] = '{4'h1, 4'h7, 4'h7, 4'h7, 4'h7, 4'h7, 4'h7, 4'hF, 4'hF, 4'h8, 4'h8, 4'hF, 4'h8, 4'h9};
    logic       ts[14] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 0};
    logic [2:0] tc[14] = '{3'b010, 3'b010, 3'b100, 3'b001, 3'b000, 3'b111, 3'b011,
                           3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b000, 3'b100};
    logic [2:0] te[14] = '{3'b100, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001,
                           3'b001, 3'b100, 3'b001, 3'b100, 3'b001, 3'b010, 3'b001};
    logic [2:0] got;
    logic [2:0] want;
    for (int i = 0; i < 14; i++) begin
      got = tc[i];
      send(ta[i], tb[i], ts[i], got[2], got[1], got[0], te[i]);
      @(negedge clk);
      want = exp_q.pop_front();
      checks++;
      if ({out_valid, gt, eq, lt} !== {1'b1, want}) begin
        errors++;
        $display("FAIL directed[%0d] x=%h y=%h sm=%0d: got {ov,gt,eq,lt}=%b want %b",
                 i, ta[i], tb[i], ts[i], {out_valid, gt, eq, lt}, {1'b1, want});
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic [2:0] want;
    logic [2:0] last;
    send(4'h5, 4'h2, 1'b0, 1'b0, 1'b1, 1'b0, 3'b100);
    @(negedge clk);
    send(4'hC, 4'h4, 1'b1, 1'b0, 1'b1, 1'b0, 3'b001);
    @(negedge clk);
    send(4'h9, 4'h9, 1'b0, 1'b0, 1'b1, 1'b0, 3'b010);
    @(negedge clk);
    in_valid = 1'b0;
    last = 3'bxxx;
    while (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      last = want;
    end
    // Only the final result remains visible; earlier ones checked via a second pass below.
    checks++;
    if ({out_valid, gt, eq, lt} !== {1'b1, last}) begin
      errors++;
      $display("FAIL b2b_third: got {ov,gt,eq,lt}=%b want %b", {out_valid, gt, eq, lt}, {1'b1, last});
    end
    @(negedge clk);
    checks++;
    if ({out_valid, gt, eq, lt} !== {1'b0, last}) begin
      errors++;
      $display("FAIL b2b_hold: got {ov,gt,eq,lt}=%b want %b", {out_valid, gt, eq, lt}, {1'b0, last});
    end
    // Second pass: verify each streamed result as it appears, with no bubbles.
    for (int i = 0; i < 3; i++) begin
      if (i == 0) send(4'h1, 4'hE, 1'b1, 1'b0, 1'b1, 1'b0, 3'b100);
      if (i == 1) send(4'h6, 4'h6, 1'b1, 1'b0, 1'b0, 1'b1, 3'b001);
      if (i == 2) send(4'hF, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b100);
      @(negedge clk);
      want = exp_q.pop_front();
      checks++;
      if ({out_valid, gt, eq, lt} !== {1'b1, want}) begin
        errors++;
        $display("FAIL b2b_stream[%0d]: got {ov,gt,eq,lt}=%b want %b", i, {out_valid, gt, eq, lt}, {1'b1, want});
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_valid, gt, eq, lt} !== 4'b0100) begin
      errors++;
      $display("FAIL b2b_drop: got {ov,gt,eq,lt}=%b want 0100", {out_valid, gt, eq, lt});
    end
  endtask

  task automatic test_async_reset;
    logic [2:0] want;
    send(4'h2, 4'h8, 1'b0, 1'b0, 1'b1, 1'b0, 3'b001);
    @(negedge clk);
    want = exp_q.pop_front();
    checks++;
    if ({out_valid, gt, eq, lt} !== {1'b1, want}) begin
      errors++;
      $display("FAIL pre_rst: got {ov,gt,eq,lt}=%b want %b", {out_valid, gt, eq, lt}, {1'b1, want});
    end
    send(4'hA, 4'h3, 1'b0, 1'b0, 1'b1, 1'b0, 3'b100);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, gt, eq, lt} !== 4'b0000) begin
      errors++;
      $display("FAIL rst_async: got {ov,gt,eq,lt}=%b want 0000", {out_valid, gt, eq, lt});
    end
    void'(exp_q.pop_front());
    @(negedge clk);
    checks++;
    if ({out_valid, gt, eq, lt} !== 4'b0000) begin
      errors++;
      $display("FAIL rst_discard: got {ov,gt,eq,lt}=%b want 0000", {out_valid, gt, eq, lt});
    end
    in_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    send(4'hA, 4'h3, 1'b1, 1'b0, 1'b1, 1'b0, 3'b001);
    @(negedge clk);
    want = exp_q.pop_front();
    checks++;
    if ({out_valid, gt, eq, lt} !== {1'b1, want}) begin
      errors++;
      $display("FAIL post_rst: got {ov,gt,eq,lt}=%b want %b", {out_valid, gt, eq, lt}, {1'b1, want});
    end
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_sweep;
    logic [2:0] want;
    logic [2:0] c;
    for (int m = 0; m < 2; m++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          c = 3'($urandom_range(0, 7));
          send(4'(a), 4'(b), m[0], c[2], c[1], c[0], model(4'(a), 4'(b), m[0], c[2], c[0]));
          @(negedge clk);
          want = exp_q.pop_front();
          checks++;
          if ({out_valid, gt, eq, lt} !== {1'b1, want}) begin
            errors++;
            $display("FAIL sweep sm=%0d x=%h y=%h casc=%b: got {ov,gt,eq,lt}=%b want %b",
                     m, a, b, c, {out_valid, gt, eq, lt}, {1'b1, want});
          end
        end
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d entries want 0", exp_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_async_reset();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
